// File: rtl/wddl_pkg.sv
// Shared WDDL definitions: scheduler state encoding, dual-rail code points
// and per-bit rail classification helpers used by WDDL controllers.
package wddl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRECH,
      EVAL,
      DONE
   } state_t;

   // Dual-rail code points, packed as {p, n}
   localparam logic [1:0] PRECHARGE = 2'b00;
   localparam logic [1:0] VALID0    = 2'b01;
   localparam logic [1:0] VALID1    = 2'b10;
   localparam logic [1:0] COLLIDE   = 2'b11;

   function automatic logic [1:0] rail_code(input logic p, input logic n);
      return {p, n};
   endfunction

   function automatic logic rail_valid(input logic p, input logic n);
      return (rail_code(p, n) == VALID0) || (rail_code(p, n) == VALID1);
   endfunction

   function automatic logic rail_collide(input logic p, input logic n);
      return rail_code(p, n) == COLLIDE;
   endfunction

   function automatic logic rail_precharged(input logic p, input logic n);
      return rail_code(p, n) == PRECHARGE;
   endfunction

endpackage

// File: rtl/wddl_rr_arb.sv
// Round-robin one-hot picker. Searches req_in starting at ptr_in and wrapping;
// purely combinational.
//   req_in   request vector
//   ptr_in   index that has highest priority this round
//   gnt_out  one-hot winner (all zero when no request)
//   idx_out  binary index of the winner
module wddl_rr_arb #(
   parameter int NREQ = 4,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_in,
   input  logic [PW-1:0]   ptr_in,
   output logic [NREQ-1:0] gnt_out,
   output logic [PW-1:0]   idx_out
);

   logic [PW-1:0] cand;
   logic          found;

   always_comb begin
      gnt_out = '0;
      idx_out = '0;
      found   = 1'b0;
      cand    = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = PW'((int'(ptr_in) + i) % NREQ);
         if (!found && req_in[cand]) begin
            found         = 1'b1;
            gnt_out[cand] = 1'b1;
            idx_out       = cand;
         end
      end
   end

endmodule

// File: rtl/wddl_xor_sched.sv
// Time-shares one external 5-operand WDDL dual-rail XOR tree between NREQ
// requesters. Every evaluation is preceded by a precharge wave (all rails 0);
// completion is detected on the tree output and the result is captured.
//   clk_in, rst_in        clock, async active-high reset
//   req_in, op_p/n_in     per-requester request and dual-rail operands
//   gnt_out               one-hot grant, held from precharge through done
//   x_p/n_out             registered operand rails to the tree (0 = precharge)
//   r_p/n_in              tree output rails
//   res_p/n_out           captured result (0/0 after an error)
//   done_out, err_out     one-cycle completion / error pulses
//   busy_out              high whenever not idle
//
// state | meaning
// IDLE  | waiting for any request, arbitrates round robin
// PRECH | rails held at 0 until the tree output is discharged
// EVAL  | granted operands driven, waiting for a complete code or timeout
// DONE  | one-cycle completion pulse, pointer advanced, grant released
module wddl_xor_sched
   import wddl_pkg::*;
#(
   parameter int WIDTH   = 1,
   parameter int NREQ    = 4,
   parameter int PRE_CYC = 1,
   parameter int TMO_CYC = 8
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic [NREQ-1:0]         req_in,
   input  logic [NREQ*5*WIDTH-1:0] op_p_in,
   input  logic [NREQ*5*WIDTH-1:0] op_n_in,
   output logic [NREQ-1:0]         gnt_out,
   output logic [5*WIDTH-1:0]      x_p_out,
   output logic [5*WIDTH-1:0]      x_n_out,
   input  logic [WIDTH-1:0]        r_p_in,
   input  logic [WIDTH-1:0]        r_n_in,
   output logic [WIDTH-1:0]        res_p_out,
   output logic [WIDTH-1:0]        res_n_out,
   output logic [NREQ-1:0]         done_out,
   output logic                    err_out,
   output logic                    busy_out
);

   localparam int OPW  = 5 * WIDTH;
   localparam int PW   = $clog2(NREQ);
   localparam int CMAX = (PRE_CYC > TMO_CYC) ? PRE_CYC : TMO_CYC;
   localparam int CW   = $clog2(CMAX) + 1;
   localparam logic [CW-1:0] PRE_LD = CW'(PRE_CYC - 1);
   localparam logic [CW-1:0] TMO_LD = CW'(TMO_CYC - 1);

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [PW-1:0]     idx_q, idx_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [OPW-1:0]    x_p_q, x_p_d, x_n_q, x_n_d;
   logic [WIDTH-1:0]  res_p_q, res_p_d, res_n_q, res_n_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;

   logic [NREQ-1:0]   arb_gnt;
   logic [PW-1:0]     arb_idx;
   logic              all_valid, any_collide, all_pre;

   wddl_rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
      .req_in  (req_in),
      .ptr_in  (ptr_q),
      .gnt_out (arb_gnt),
      .idx_out (arb_idx)
   );

   always_comb begin
      all_valid   = 1'b1;
      any_collide = 1'b0;
      all_pre     = 1'b1;
      for (int b = 0; b < WIDTH; b++) begin
         all_valid   = all_valid & rail_valid(r_p_in[b], r_n_in[b]);
         any_collide = any_collide | rail_collide(r_p_in[b], r_n_in[b]);
         all_pre     = all_pre & rail_precharged(r_p_in[b], r_n_in[b]);
      end
   end

   // Timers are down-counters: reaching zero is the terminal count.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      x_p_d   = '0;
      x_n_d   = '0;
      res_p_d = res_p_q;
      res_n_d = res_n_q;
      done_d  = '0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req_in) begin
               gnt_d   = arb_gnt;
               idx_d   = arb_idx;
               cnt_d   = PRE_LD;
               state_d = PRECH;
            end
         end
         PRECH: begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0 && all_pre) begin
               cnt_d   = TMO_LD;
               state_d = EVAL;
               for (int i = 0; i < NREQ; i++) begin
                  if (idx_q == PW'(i)) begin
                     x_p_d = op_p_in[i*OPW +: OPW];
                     x_n_d = op_n_in[i*OPW +: OPW];
                  end
               end
            end
         end
         EVAL: begin
            x_p_d = x_p_q;
            x_n_d = x_n_q;
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            // A collision outranks a complete-looking code; both end the op.
            if (any_collide || (!all_valid && cnt_q == '0)) begin
               err_d   = 1'b1;
               res_p_d = '0;
               res_n_d = '0;
            end else if (all_valid) begin
               res_p_d = r_p_in;
               res_n_d = r_n_in;
            end
            if (any_collide || all_valid || cnt_q == '0) begin
               x_p_d   = '0;
               x_n_d   = '0;
               done_d  = gnt_q;
               state_d = DONE;
            end
         end
         DONE: begin
            gnt_d   = '0;
            ptr_d   = (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         gnt_q   <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
         x_p_q   <= '0;
         x_n_q   <= '0;
         res_p_q <= '0;
         res_n_q <= '0;
         done_q  <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         x_p_q   <= x_p_d;
         x_n_q   <= x_n_d;
         res_p_q <= res_p_d;
         res_n_q <= res_n_d;
         done_q  <= done_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   assign gnt_out   = gnt_q;
   assign x_p_out   = x_p_q;
   assign x_n_out   = x_n_q;
   assign res_p_out = res_p_q;
   assign res_n_out = res_n_q;
   assign done_out  = done_q;
   assign err_out   = err_q;
   assign busy_out  = busy_q;

endmodule

// File: tb/tb_wddl_xor_sched.sv
// Scoreboard bench for wddl_xor_sched with a behavioural XOR-tree model.
module tb_wddl_xor_sched;

   localparam int W   = 2;
   localparam int N   = 4;
   localparam int PRE = 1;
   localparam int TMO = 8;
   localparam int OPW = 5 * W;

   localparam int M_NORMAL  = 0;
   localparam int M_NEVER   = 1;
   localparam int M_COLLIDE = 2;

   logic             clk_in = 1'b0;
   logic             rst_in;
   logic [N-1:0]     req_in;
   logic [N*OPW-1:0] op_p_in, op_n_in;
   logic [N-1:0]     gnt_out;
   logic [OPW-1:0]   x_p_out, x_n_out;
   logic [W-1:0]     r_p_in, r_n_in;
   logic [W-1:0]     res_p_out, res_n_out;
   logic [N-1:0]     done_out;
   logic             err_out, busy_out;

   wddl_xor_sched #(.WIDTH(W), .NREQ(N), .PRE_CYC(PRE), .TMO_CYC(TMO)) dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .req_in    (req_in),
      .op_p_in   (op_p_in),
      .op_n_in   (op_n_in),
      .gnt_out   (gnt_out),
      .x_p_out   (x_p_out),
      .x_n_out   (x_n_out),
      .r_p_in    (r_p_in),
      .r_n_in    (r_n_in),
      .res_p_out (res_p_out),
      .res_n_out (res_n_out),
      .done_out  (done_out),
      .err_out   (err_out),
      .busy_out  (busy_out)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   int tree_mode = M_NORMAL;
   int hot_left  = 0;
   bit arm_stall = 1'b0;

   // Tree environment: precharged in -> 00 out, otherwise mode-dependent.
   logic [W-1:0] acc;
   always_comb begin
      r_p_in = '0;
      r_n_in = '0;
      acc    = '0;
      for (int k = 0; k < 5; k++) acc = acc ^ x_p_out[k*W +: W];
      if (hot_left > 0) begin
         r_p_in = '1;
      end else if (x_p_out != '0 || x_n_out != '0) begin
         if (tree_mode == M_NORMAL) begin
            r_p_in = acc;
            r_n_in = ~acc;
         end else if (tree_mode == M_COLLIDE) begin
            r_p_in = '1;
            r_n_in = '1;
         end
      end
   end

   typedef struct {
      logic [N-1:0]   gnt;
      logic [OPW-1:0] xp;
      logic [OPW-1:0] xn;
      logic [W-1:0]   rp;
      logic [W-1:0]   rn;
      logic           err;
      int             pre;
      int             ev;
   } exp_t;

   exp_t           sb[$];
   logic [OPW-1:0] opp [N];
   int             m_ptr = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_item(input int idx, input int mode, input int pre);
      exp_t         e;
      logic [W-1:0] x;
      x = '0;
      for (int k = 0; k < 5; k++) x = x ^ opp[idx][k*W +: W];
      e.gnt      = '0;
      e.gnt[idx] = 1'b1;
      e.xp       = opp[idx];
      e.xn       = ~opp[idx];
      e.pre      = pre;
      if (mode == M_NORMAL) begin
         e.rp = x; e.rn = ~x; e.err = 1'b0; e.ev = 1;
      end else begin
         e.rp = '0; e.rn = '0; e.err = 1'b1;
         e.ev = (mode == M_NEVER) ? TMO : 1;
      end
      sb.push_back(e);
   endtask

   // All requests of a batch are held until served, so service order is the
   // rotation starting at the pointer.
   task automatic model_batch(input logic [N-1:0] set, input int mode, input int pre);
      int p0, idx, last;
      p0   = m_ptr;
      last = -1;
      for (int k = 0; k < N; k++) begin
         idx = (p0 + k) % N;
         if (set[idx]) begin
            push_item(idx, mode, pre);
            last = idx;
         end
      end
      if (last >= 0) m_ptr = (last + 1) % N;
   endtask

   task automatic apply_ops();
      for (int i = 0; i < N; i++) begin
         op_p_in[i*OPW +: OPW] = opp[i];
         op_n_in[i*OPW +: OPW] = ~opp[i];
      end
   endtask

   task automatic rand_ops();
      for (int i = 0; i < N; i++) opp[i] = OPW'($urandom);
   endtask

   task automatic run_batch(input logic [N-1:0] set, input int mode, input int pre,
                            output int first_done);
      int budget;
      tree_mode = mode;
      model_batch(set, mode, pre);
      apply_ops();
      req_in     = set;
      first_done = -1;
      budget     = 0;
      while (req_in != '0 && budget < 300) begin
         @(negedge clk_in);
         budget++;
         if (done_out != '0 && first_done < 0) first_done = cyc;
         req_in = req_in & ~done_out;
      end
      chk("batch_served", req_in, '0);
      req_in = '0;
   endtask

   task automatic run_held(input int n);
      int cnt, budget;
      tree_mode = M_NORMAL;
      apply_ops();
      for (int k = 0; k < n; k++) begin
         push_item(m_ptr, M_NORMAL, 1);
         m_ptr = (m_ptr + 1) % N;
      end
      req_in = '1;
      cnt    = 0;
      budget = 0;
      while (cnt < n && budget < 300) begin
         @(negedge clk_in);
         budget++;
         if (done_out != '0) cnt++;
      end
      req_in = '0;
      chk("held_ops", cnt, n);
   endtask

   // Monitor: phase tracking plus scoreboard pop on every done pulse.
   initial begin
      logic [N-1:0] prev_gnt;
      bit           in_pre, in_eval;
      int           pre_n, eval_n;
      exp_t         e;
      prev_gnt = '0; in_pre = 0; in_eval = 0; pre_n = 0; eval_n = 0;
      forever begin
         @(negedge clk_in);
         if (hot_left > 0) hot_left--;
         if (rst_in) begin
            prev_gnt = '0; in_pre = 0; in_eval = 0; hot_left = 0;
         end else begin
            if (gnt_out != '0 && prev_gnt == '0) begin
               in_pre = 1; pre_n = 0;
               chk("prech_x_zero", {x_p_out, x_n_out}, '0);
               if (arm_stall) begin
                  hot_left  = 3;
                  arm_stall = 1'b0;
               end
            end
            if ((x_p_out != '0 || x_n_out != '0) && !in_eval) begin
               in_eval = 1; in_pre = 0; eval_n = 0;
               if (sb.size() == 0) begin
                  chk("x_without_op", 1, 0);
               end else begin
                  chk("x_p_oper", x_p_out, sb[0].xp);
                  chk("x_n_oper", x_n_out, sb[0].xn);
                  chk("prech_cycles", pre_n, sb[0].pre);
               end
            end
            if (in_pre && x_p_out == '0 && x_n_out == '0 && done_out == '0) pre_n++;
            if (in_eval && (x_p_out != '0 || x_n_out != '0)) eval_n++;
            if (done_out != '0) begin
               if (sb.size() == 0) begin
                  chk("done_without_op", done_out, '0);
               end else begin
                  e = sb.pop_front();
                  chk("done_onehot", done_out, e.gnt);
                  chk("gnt_at_done", gnt_out, e.gnt);
                  chk("err_at_done", err_out, e.err);
                  chk("res_p", res_p_out, e.rp);
                  chk("res_n", res_n_out, e.rn);
                  chk("eval_cycles", eval_n, e.ev);
                  chk("busy_at_done", busy_out, 1);
               end
               in_eval = 0; in_pre = 0;
            end else begin
               chk("err_without_done", err_out, 0);
            end
            prev_gnt = gnt_out;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int           t0, fd, b, r, md;
      logic [N-1:0] s;
      rst_in  = 1'b1;
      req_in  = '0;
      op_p_in = '0;
      op_n_in = '0;
      for (int i = 0; i < N; i++) opp[i] = '0;
      repeat (3) @(negedge clk_in);
      chk("rst_gnt", gnt_out, '0);
      chk("rst_x", {x_p_out, x_n_out}, '0);
      chk("rst_res", {res_p_out, res_n_out}, '0);
      chk("rst_done_err", {done_out, err_out}, '0);
      chk("rst_busy", busy_out, 0);
      rst_in = 1'b0;
      m_ptr  = 0;
      @(negedge clk_in);

      // Held all-request: rotation 0,1,2,3,0
      rand_ops();
      run_held(5);
      repeat (2) @(negedge clk_in);

      // Single request, d0..d2 = ones, d3..d4 = zeros
      opp[0] = {{W{1'b0}}, {W{1'b0}}, {W{1'b1}}, {W{1'b1}}, {W{1'b1}}};
      t0 = cyc;
      run_batch(4'b0001, M_NORMAL, 1, fd);
      chk("t1_latency", fd - t0 + 1, 4);
      chk("t1_res_p", res_p_out, {W{1'b1}});
      chk("t1_res_n", res_n_out, '0);

      // Tree slow to discharge: 3 extra precharge cycles
      rand_ops();
      arm_stall = 1'b1;
      run_batch(4'b0100, M_NORMAL, 4, fd);

      // Tree never completes -> timeout
      rand_ops();
      run_batch(4'b0010, M_NEVER, 1, fd);
      chk("t4_res_zero", {res_p_out, res_n_out}, '0);

      // Rail collision
      rand_ops();
      run_batch(4'b1000, M_COLLIDE, 1, fd);

      // Randomized batches
      for (int n = 0; n < 30; n++) begin
         rand_ops();
         s  = N'($urandom_range(1, (1 << N) - 1));
         r  = $urandom_range(0, 7);
         md = (r < 6) ? M_NORMAL : ((r == 6) ? M_NEVER : M_COLLIDE);
         run_batch(s, md, 1, fd);
      end

      // Reset mid-EVAL, then restart from pointer 0
      rand_ops();
      run_batch(4'b0010, M_NORMAL, 1, fd);
      rand_ops();
      tree_mode = M_NEVER;
      model_batch(4'b1000, M_NEVER, 1);
      apply_ops();
      req_in = 4'b1000;
      b = 0;
      while (x_p_out == '0 && b < 30) begin
         @(negedge clk_in);
         b++;
      end
      chk("t6_reached_eval", x_p_out != '0, 1);
      @(negedge clk_in);
      chk("t6_busy_before", busy_out, 1);
      #2 rst_in = 1'b1;
      #1;
      chk("t6_gnt", gnt_out, '0);
      chk("t6_x", {x_p_out, x_n_out}, '0);
      chk("t6_busy", busy_out, 0);
      chk("t6_done_err", {done_out, err_out}, '0);
      sb.delete();
      m_ptr  = 0;
      req_in = '0;
      repeat (2) @(negedge clk_in);
      rst_in    = 1'b0;
      tree_mode = M_NORMAL;
      @(negedge clk_in);
      rand_ops();
      run_batch(4'b1010, M_NORMAL, 1, fd);

      repeat (4) @(negedge clk_in);
      chk("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
